// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus controller.
// Slave count, read-select encoding and FSM state type.
package periph_bus_pkg;

  localparam int NSLAVES = 5;
  localparam logic [2:0] RDSEL_NONE = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } bus_state_t;

  typedef logic [2:0] rdsel_t;

endpackage

// File: rtl/periph_addr_decode.sv
// Address decoder: maps the 4 KB page field onto slaves 0..4.
// Anything above page 4, or with high bits set, is unmapped.
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PAGE_LSB   = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  mapped_o,
  output rdsel_t                idx_o
);

  logic [3:0] page;
  logic [ADDR_WIDTH-PAGE_LSB-5:0] hi;
  logic unused_lsb;

  assign page = addr_i[PAGE_LSB+3:PAGE_LSB];
  assign hi   = addr_i[ADDR_WIDTH-1:PAGE_LSB+4];
  assign unused_lsb = ^addr_i[PAGE_LSB-1:0];

  assign mapped_o = (hi == '0) && (page <= 4'd4);
  assign idx_o    = page[2:0];

endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: req/ack front end, strobe generation,
// per-slave latency counting and registered mux read-select.
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PAGE_LSB   = 12,
  parameter int LAT0       = 1,
  parameter int LAT1       = 1,
  parameter int LAT2       = 1,
  parameter int LAT3       = 1,
  parameter int LAT4       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [NSLAVES-1:0]    cs_o,
  output logic [NSLAVES-1:0]    we_o,
  output logic [2:0]            rdsel_o
);

  logic   mapped;
  rdsel_t idx;

  periph_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PAGE_LSB  (PAGE_LSB)
  ) u_dec (
    .addr_i  (addr_i),
    .mapped_o(mapped),
    .idx_o   (idx)
  );

  bus_state_t         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [NSLAVES-1:0] cs_q, cs_d;
  logic [NSLAVES-1:0] we_q, we_d;
  rdsel_t             rdsel_q, rdsel_d;
  logic [3:0]         lat_m1;
  logic [NSLAVES-1:0] onehot;

  always_comb begin
    case (idx)
      3'd0:    lat_m1 = 4'(LAT0 - 1);
      3'd1:    lat_m1 = 4'(LAT1 - 1);
      3'd2:    lat_m1 = 4'(LAT2 - 1);
      3'd3:    lat_m1 = 4'(LAT3 - 1);
      3'd4:    lat_m1 = 4'(LAT4 - 1);
      default: lat_m1 = 4'd0;
    endcase
  end

  assign onehot = NSLAVES'(1) << idx;

  // Strobes and ack default low so each is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cs_d    = '0;
    we_d    = '0;
    rdsel_d = rdsel_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (mapped) begin
            rdsel_d = idx;
            cs_d    = onehot;
            we_d    = onehot & {NSLAVES{we_i}};
            cnt_d   = lat_m1;
            state_d = WAIT;
          end else begin
            rdsel_d = RDSEL_NONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= '0;
      we_q    <= '0;
      rdsel_q <= RDSEL_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      rdsel_q <= rdsel_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign cs_o    = cs_q;
  assign we_o    = we_q;
  assign rdsel_o = rdsel_q;
  assign busy_o  = (state_q != IDLE);

  a_lat_range: assert property (@(posedge clk)
    (LAT0 >= 1 && LAT0 <= 15) && (LAT1 >= 1 && LAT1 <= 15) &&
    (LAT2 >= 1 && LAT2 <= 15) && (LAT3 >= 1 && LAT3 <= 15) &&
    (LAT4 >= 1 && LAT4 <= 15));

  a_cs_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(cs_o));

  a_ack_resp: assert property (@(posedge clk) disable iff (!rst_n)
    ack_o |-> (state_q == RESP));

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: decode, strobes, latency,
// back-to-back handshake and reset during a transfer.
module tb_periph_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic        ack;
  logic        err;
  logic        busy;
  logic [4:0]  cs;
  logic [4:0]  we_s;
  logic [2:0]  rdsel;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] last_rdsel = 3'b111;

  periph_bus_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .ack_o  (ack),
    .err_o  (err),
    .busy_o (busy),
    .cs_o   (cs),
    .we_o   (we_s),
    .rdsel_o(rdsel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer from an IDLE negedge; ack cycle n counted in negedges after E0.
  task automatic xfer(input logic w, input logic [31:0] a,
                      input int n_exp, input logic [4:0] ecs,
                      input logic [4:0] ewe, input logic eerr,
                      input logic [2:0] ersel, input logic scramble);
    int ackat;
    int bcnt;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("rdsel_hold", 32'(rdsel), 32'(last_rdsel));
    req  = 1'b1;
    we   = w;
    addr = a;
    ackat = 0;
    bcnt  = 0;
    for (int n = 1; n <= 20 && ackat == 0; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (n == 1) begin
        chk("cs_first", 32'(cs), 32'(ecs));
        chk("we_first", 32'(we_s), 32'(ewe));
        chk("rdsel_first", 32'(rdsel), 32'(ersel));
        if (scramble) begin
          addr = 32'h0000_5000;
          we   = ~w;
        end
      end
      if (n == 2) chk("cs_second", 32'(cs), 0);
      if (ack) begin
        ackat = n;
        chk("err_at_ack", 32'(err), 32'(eerr));
        chk("rdsel_at_ack", 32'(rdsel), 32'(ersel));
        req = 1'b0;
      end
    end
    chk("ack_cycle", 32'(ackat), 32'(n_exp));
    chk("busy_cycles", 32'(bcnt), 32'(n_exp));
    last_rdsel = ersel;
  endtask

  initial begin
    int acks;
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cs", 32'(cs), 0);
    chk("rst_we", 32'(we_s), 0);
    chk("rst_rdsel", 32'(rdsel), 32'h7);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // read slave 1, LAT=1
    xfer(1'b0, 32'h0000_1004, 2, 5'b00010, 5'b00000, 1'b0, 3'd1, 1'b0);
    // write slave 4, LAT=4; inputs disturbed during WAIT
    xfer(1'b1, 32'h0000_4000, 5, 5'b10000, 5'b10000, 1'b0, 3'd4, 1'b1);
    // unmapped pages
    xfer(1'b0, 32'h0000_5000, 1, 5'b00000, 5'b00000, 1'b1, 3'd7, 1'b0);
    xfer(1'b0, 32'h0001_0000, 1, 5'b00000, 5'b00000, 1'b1, 3'd7, 1'b0);
    // back-to-back, one IDLE cycle between
    xfer(1'b0, 32'h0000_0000, 2, 5'b00001, 5'b00000, 1'b0, 3'd0, 1'b0);
    xfer(1'b0, 32'h0000_2000, 2, 5'b00100, 5'b00000, 1'b0, 3'd2, 1'b0);
    xfer(1'b1, 32'h0000_3ffc, 2, 5'b01000, 5'b01000, 1'b0, 3'd3, 1'b0);

    // reset during WAIT of a LAT4 write
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b1;
    addr = 32'h0000_4010;
    @(negedge clk);
    chk("r6_cs", 32'(cs), 32'h10);
    req = 1'b0;
    @(negedge clk);
    chk("r6_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r6_busy", 32'(busy), 0);
    chk("r6_rdsel", 32'(rdsel), 32'h7);
    chk("r6_cs_rst", 32'(cs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("r6_no_ack", 32'(acks), 0);
    last_rdsel = 3'b111;
    xfer(1'b0, 32'h0000_3000, 2, 5'b01000, 5'b00000, 1'b0, 3'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
